// File: rtl/lzs_stream_pkg.sv
// rtl/lzs_stream_pkg.sv - shared LZS bit-stream constants, state encoding and helpers
// Purpose: constants and types common to the encoder output stage and the
//          decoder input stage.
// Contents: LZS_CODE_W, LZS_HW_W, LZS_WORD_W, LZS_LANES, lzs_state_e,
//           lzs_sat_width() (clamps a code width to LZS_CODE_W).
package lzs_stream_pkg;
  localparam int LZS_CODE_W = 13;
  localparam int LZS_HW_W   = 16;
  localparam int LZS_WORD_W = 64;
  localparam int LZS_LANES  = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } lzs_state_e;

  function automatic logic [3:0] lzs_sat_width(input logic [3:0] w);
    return (w > 4'd13) ? 4'd13 : w;
  endfunction
endpackage

// File: rtl/encode_out_if.sv
// rtl/encode_out_if.sv - code handshake bundle between token encoder and output stage
// Purpose: groups the variable-width code handshake.
// Signals: code_data (LSB-aligned bits), code_width (valid bit count),
//          code_valid (producer), code_ready (consumer).
// Modports: master = token encoder side, slave = encode_out side.
interface encode_out_if;
  import lzs_stream_pkg::*;

  logic [LZS_CODE_W-1:0] code_data;
  logic [3:0]            code_width;
  logic                  code_valid;
  logic                  code_ready;

  modport master (output code_data, code_width, code_valid, input code_ready);
  modport slave  (input code_data, code_width, code_valid, output code_ready);
endinterface

// File: rtl/lzs_word_pack.sv
// rtl/lzs_word_pack.sv - halfword to 64-bit lane assembler with FIFO put
// Purpose: places 16-bit stream halfwords into four byte-swapped lanes and
//          writes the completed word to the destination FIFO.
// Ports: clk, rst (async, active-high), ce; hw_valid/hw_data/hw_ready halfword
//        input; fo_full FIFO status; hw_cnt filled lanes; put write strobe;
//        fo word being assembled (presented to the FIFO on put).
module lzs_word_pack
  import lzs_stream_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  hw_valid,
  input  logic [LZS_HW_W-1:0]   hw_data,
  input  logic                  fo_full,
  output logic                  hw_ready,
  output logic [2:0]            hw_cnt,
  output logic                  put,
  output logic [LZS_WORD_W-1:0] fo
);
  logic [LZS_WORD_W-1:0] wbuf_q, wbuf_d;
  logic [2:0]            hw_cnt_q, hw_cnt_d;
  logic [1:0]            lane;

  always_comb begin
    put      = ce & (hw_cnt_q == 3'(LZS_LANES)) & ~fo_full;
    // A full buffer can still take a halfword in the cycle it is written out.
    hw_ready = ce & ((hw_cnt_q < 3'(LZS_LANES)) | put);
    lane     = put ? 2'd0 : hw_cnt_q[1:0];
    wbuf_d   = put ? '0 : wbuf_q;
    hw_cnt_d = put ? 3'd0 : hw_cnt_q;
    if (hw_valid && hw_ready) begin
      // Byte swap so the first stream byte of each halfword lands in the low byte.
      wbuf_d[{lane, 4'b0000} +: LZS_HW_W] = {hw_data[7:0], hw_data[15:8]};
      hw_cnt_d = hw_cnt_d + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_q   <= '0;
      hw_cnt_q <= 3'd0;
    end else begin
      wbuf_q   <= wbuf_d;
      hw_cnt_q <= hw_cnt_d;
    end
  end

  assign hw_cnt = hw_cnt_q;
  assign fo     = wbuf_q;
endmodule

// File: rtl/encode_out.sv
// rtl/encode_out.sv - LZS encoder output stage: MSB-first code packer with flush
// Purpose: packs 1..13 bit codes MSB-first into a bit stream and emits 64-bit
//          words; flush zero-pads the stream to a word boundary.
// Ports: clk, rst (async, active-high), ce (chip enable), code_if (code
//        handshake, slave side), flush/flush_done (pad request and completion
//        pulse), fo_full (FIFO full), m_dst_putn (active-low write, Z when
//        ce=0), fo (FIFO write data).
module encode_out
  import lzs_stream_pkg::*;
#(
  parameter int CODE_W = 13,
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  encode_out_if.slave       code_if,
  input  logic              flush,
  output logic              flush_done,
  input  logic              fo_full,
  output wire               m_dst_putn,
  output logic [WORD_W-1:0] fo
);
  lzs_state_e        state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [5:0]        nbits_q, nbits_d;
  logic [3:0]        width_sat;
  logic [CODE_W-1:0] code_mask;
  logic [5:0]        shamt;
  logic [31:0]       code_aligned;
  logic              accept, have_hw, zero_lane, hw_valid, hw_ready, put;
  logic [2:0]        hw_cnt;

  always_comb begin
    width_sat    = lzs_sat_width(code_if.code_width);
    code_mask    = (CODE_W'(1) << width_sat) - CODE_W'(1);
    shamt        = 6'd32 - nbits_q - {2'b00, width_sat};
    code_aligned = 32'(code_if.code_data & code_mask) << shamt;

    code_ready_o: begin end
    code_if.code_ready = ce & (state_q == ST_RUN) & (nbits_q < 6'd16);
    accept     = code_if.code_ready & code_if.code_valid;
    have_hw    = (nbits_q >= 6'd16);
    zero_lane  = ce & (state_q == ST_FLUSH) & (nbits_q == 6'd0) &
                 (hw_cnt != 3'd0) & (hw_cnt != 3'(LZS_LANES));
    // acc is all zero when nbits==0, so acc[31:16] doubles as the pad lane.
    hw_valid   = have_hw | zero_lane;
    flush_done = ce & (state_q == ST_FLUSH) & (nbits_q == 6'd0) & (hw_cnt == 3'd0);

    acc_d   = acc_q;
    nbits_d = nbits_q;
    state_d = state_q;
    if (accept) begin
      acc_d   = acc_q | code_aligned;
      nbits_d = nbits_q + {2'b00, width_sat};
    end
    if (have_hw && hw_ready) begin
      acc_d   = acc_q << 16;
      nbits_d = nbits_q - 6'd16;
    end
    if (ce) begin
      case (state_q)
        ST_RUN: begin
          if (flush) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          // Padding bits below the pending ones are already zero.
          if (nbits_q != 6'd0 && nbits_q < 6'd16) nbits_d = 6'd16;
          else if (flush_done)                    state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      acc_q   <= '0;
      nbits_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      nbits_q <= nbits_d;
    end
  end

  lzs_word_pack u_pack (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .hw_valid (hw_valid),
    .hw_data  (acc_q[31:16]),
    .fo_full  (fo_full),
    .hw_ready (hw_ready),
    .hw_cnt   (hw_cnt),
    .put      (put),
    .fo       (fo)
  );

  assign m_dst_putn = ce ? ~put : 1'bz;
endmodule
